arbitro_mux4: RTL and testbench

//  Round-robin arbiter that shares one mux4 datapath between four requesters.

---
 rtl/arbitro_mux4.sv | 197 +++++++++++++++++++
 tb/tb_arbitro_mux4.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/arbitro_mux4.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_mux4 (with embedded helper mux4)
//  Purpose  : Round-robin arbiter sharing one 4:1 mux datapath between four
//             requesters. A winner keeps the bus for at most MAX_RAFAGA
//             consecutive cycles, then the grant rotates to the next active
//             requester with no idle gap.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous reset, active-high
//             req[3:0] - per-requester bus request
//             e0..e3   - requester data, WIDTH bits each
//             gnt[3:0] - one-hot grant (registered), 0000 when idle
//             en       - mux enable (registered), 1 while a grant is active
//             sel[1:0] - mux select (registered), index of the grantee
//             s        - shared bus: e[sel] when en=1, else 0 (combinational)
//  Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
//  mux4 : gated 4:1 multiplexer. Output is forced to zero while disabled.
// ----------------------------------------------------------------------------
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic [WIDTH-1:0] e3,
    output logic [WIDTH-1:0] s
);
    always_comb begin
        s = '0;
        if (en) begin
            case (sel)
                2'd0:    s = e0;
                2'd1:    s = e1;
                2'd2:    s = e2;
                default: s = e3;
            endcase
        end
    end
endmodule

// ----------------------------------------------------------------------------
//  arbitro_mux4 : round-robin arbiter driving one mux4 instance.
// ----------------------------------------------------------------------------
module arbitro_mux4 #(
    parameter int WIDTH      = 8,
    parameter int MAX_RAFAGA = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic [WIDTH-1:0] e3,
    output logic [3:0]       gnt,
    output logic             en,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] s
);
    localparam int             CW    = $clog2(MAX_RAFAGA + 1);
    localparam logic [CW-1:0]  c_max = CW'(MAX_RAFAGA);

    typedef enum logic [0:0] {
        LIBRE     = 1'b0,
        CONCEDIDO = 1'b1
    } state_t;

    state_t        r_state,    w_state_nxt;
    logic [1:0]    r_ptr,      w_ptr_nxt;
    logic [1:0]    r_sel,      w_sel_nxt;
    logic          r_en,       w_en_nxt;
    logic [3:0]    r_gnt,      w_gnt_nxt;
    logic [CW-1:0] r_cnt,      w_cnt_nxt;

    logic [1:0]    w_pick_free;
    logic          w_found_free;
    logic [1:0]    w_pick_rot;
    logic          w_found_rot;
    logic          w_release;

    // Idle search: ptr+1, ptr+2, ptr+3, ptr (last served is lowest priority).
    // Scanning from the farthest offset down lets the nearest hit win.
    always_comb begin
        logic [1:0] idx;
        idx          = '0;
        w_pick_free  = '0;
        w_found_free = 1'b0;
        for (int k = 3; k >= 0; k--) begin
            idx = r_ptr + 2'(k + 1);
            if (req[idx]) begin
                w_pick_free  = idx;
                w_found_free = 1'b1;
            end
        end
    end

    // Release search: sel+1..sel+3 only. The current holder is deliberately
    // excluded so it is never handed the bus back on the same edge; a lone
    // requester therefore drops to LIBRE for one cycle and is re-picked there.
    always_comb begin
        logic [1:0] idx;
        idx         = '0;
        w_pick_rot  = '0;
        w_found_rot = 1'b0;
        for (int k = 2; k >= 0; k--) begin
            idx = r_sel + 2'(k + 1);
            if (req[idx]) begin
                w_pick_rot  = idx;
                w_found_rot = 1'b1;
            end
        end
    end

    assign w_release = !req[r_sel] || (r_cnt == c_max);

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_sel_nxt   = r_sel;
        w_en_nxt    = r_en;
        w_gnt_nxt   = r_gnt;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            LIBRE: begin
                if (w_found_free) begin
                    w_state_nxt = CONCEDIDO;
                    w_sel_nxt   = w_pick_free;
                    w_en_nxt    = 1'b1;
                    w_gnt_nxt   = 4'b0001 << w_pick_free;
                    w_cnt_nxt   = CW'(1);
                end
            end
            CONCEDIDO: begin
                if (!w_release) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end else begin
                    w_ptr_nxt = r_sel;
                    if (w_found_rot) begin
                        w_sel_nxt = w_pick_rot;
                        w_gnt_nxt = 4'b0001 << w_pick_rot;
                        w_cnt_nxt = CW'(1);
                    end else begin
                        // sel keeps its last value while idle
                        w_state_nxt = LIBRE;
                        w_en_nxt    = 1'b0;
                        w_gnt_nxt   = 4'b0000;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = LIBRE;
                w_en_nxt    = 1'b0;
                w_gnt_nxt   = 4'b0000;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LIBRE;
            r_ptr   <= 2'd3;
            r_sel   <= 2'd0;
            r_en    <= 1'b0;
            r_gnt   <= 4'b0000;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign gnt = r_gnt;
    assign en  = r_en;
    assign sel = r_sel;

    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .en  (r_en),
        .sel (r_sel),
        .e0  (e0),
        .e1  (e1),
        .e2  (e2),
        .e3  (e3),
        .s   (s)
    );
endmodule
`default_nettype wire

// File: tb/tb_arbitro_mux4.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arbitro_mux4
//  Purpose  : Directed self-checking bench for arbitro_mux4. Two instances:
//             dut_a with MAX_RAFAGA=4 and dut_b with MAX_RAFAGA=1. The
//             instance not under test is held in reset and expected idle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_arbitro_mux4;
    localparam int WIDTH = 8;

    typedef struct {
        logic [3:0] gnt_a;
        logic [1:0] sel_a;
        logic [3:0] gnt_b;
        logic [1:0] sel_b;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_a, rst_b;
    logic [3:0]       req;
    logic [WIDTH-1:0] e0, e1, e2, e3;
    logic [3:0]       gnt_a, gnt_b;
    logic             en_a, en_b;
    logic [1:0]       sel_a, sel_b;
    logic [WIDTH-1:0] s_a, s_b;

    logic [WIDTH-1:0] c_data [4];
    exp_t             sb [$];
    int               n_checks = 0;
    int               n_fail   = 0;
    bit               tgt      = 1'b0;   // 0: dut_a active, 1: dut_b active

    always #5 clk = ~clk;

    arbitro_mux4 #(.WIDTH(WIDTH), .MAX_RAFAGA(4)) dut_a (
        .clk(clk), .rst(rst_a), .req(req),
        .e0(e0), .e1(e1), .e2(e2), .e3(e3),
        .gnt(gnt_a), .en(en_a), .sel(sel_a), .s(s_a)
    );

    arbitro_mux4 #(.WIDTH(WIDTH), .MAX_RAFAGA(1)) dut_b (
        .clk(clk), .rst(rst_b), .req(req),
        .e0(e0), .e1(e1), .e2(e2), .e3(e3),
        .gnt(gnt_b), .en(en_b), .sel(sel_b), .s(s_b)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag,
                             input logic [3:0] g, input logic e, input logic [1:0] sl,
                             input logic [WIDTH-1:0] so,
                             input logic [3:0] eg, input logic [1:0] es);
        logic             ee;
        logic [WIDTH-1:0] exp_s;
        ee    = (eg != 4'b0000);
        exp_s = ee ? c_data[es] : '0;
        chk({tag, ".gnt"}, g,  eg);
        chk({tag, ".en"},  e,  ee);
        chk({tag, ".sel"}, sl, es);
        chk({tag, ".s"},   so, exp_s);
    endtask

    // One cycle of stimulus; the expectation describes outputs after this edge.
    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [3:0] eg, input logic [1:0] es);
        exp_t x;
        rst_a = tgt ? 1'b1 : r;
        rst_b = tgt ? r : 1'b1;
        req   = rq;
        @(posedge clk);
        #1;
        x.gnt_a = tgt ? 4'b0000 : eg;
        x.sel_a = tgt ? 2'd0    : es;
        x.gnt_b = tgt ? eg      : 4'b0000;
        x.sel_b = tgt ? es      : 2'd0;
        sb.push_back(x);
    endtask

    // Monitor: outputs are valid every cycle, so every queued entry is checked
    // on the falling edge following its push.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            check_dut("A", gnt_a, en_a, sel_a, s_a, x.gnt_a, x.sel_a);
            check_dut("B", gnt_b, en_b, sel_b, s_b, x.gnt_b, x.sel_b);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        c_data[0] = 8'b0000_0001;
        c_data[1] = 8'b0000_0011;
        c_data[2] = 8'b0000_0111;
        c_data[3] = 8'b0000_1111;
        e0 = c_data[0];
        e1 = c_data[1];
        e2 = c_data[2];
        e3 = c_data[3];

        // 1: reset dominates an all-ones request
        repeat (2) step(1'b1, 4'b1111, 4'b0000, 2'd0);

        // 2: lone requester 2 -> 4 on, 1 off, repeating
        repeat (2) begin
            repeat (4) step(1'b0, 4'b0100, 4'b0100, 2'd2);
            step(1'b0, 4'b0100, 4'b0000, 2'd2);
        end
        repeat (2) step(1'b0, 4'b0100, 4'b0100, 2'd2);

        // 3: all requesting from reset -> 4-cycle bursts rotating 0,1,2,3,0
        step(1'b1, 4'b1111, 4'b0000, 2'd0);
        for (int i = 0; i < 4; i++) begin
            repeat (4) step(1'b0, 4'b1111, 4'(1 << i), 2'(i));
        end
        step(1'b0, 4'b1111, 4'b0001, 2'd0);

        // 4: early drop of req[0]; grant outlives the drop by one cycle
        step(1'b1, 4'b0011, 4'b0000, 2'd0);
        repeat (3) step(1'b0, 4'b0011, 4'b0001, 2'd0);
        repeat (2) step(1'b0, 4'b0010, 4'b0010, 2'd1);

        // 5: reset in the middle of a burst, then restart at requester 0
        step(1'b1, 4'b0100, 4'b0000, 2'd0);
        repeat (2) step(1'b0, 4'b0100, 4'b0100, 2'd2);
        step(1'b1, 4'b1111, 4'b0000, 2'd0);
        repeat (2) step(1'b0, 4'b1111, 4'b0001, 2'd0);

        // 6: MAX_RAFAGA=1 instance, req=1010 -> alternate 1 and 3 every cycle
        tgt = 1'b1;
        step(1'b1, 4'b1010, 4'b0000, 2'd0);
        repeat (3) begin
            step(1'b0, 4'b1010, 4'b0010, 2'd1);
            step(1'b0, 4'b1010, 4'b1000, 2'd3);
        end

        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
